// File: rtl/alu_operand_pkg.sv
// rtl/alu_operand_pkg.sv - shared types and default widths for the ALU operand select stage
package alu_operand_pkg;

  localparam int ALU_WIDTH_DEFAULT = 32;
  localparam int ALU_IMM_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    EXT_PASS     = 2'd0,
    EXT_SEXT     = 2'd1,
    EXT_ZEXT     = 2'd2,
    EXT_SEXT_SL2 = 2'd3
  } ext_mode_e;

endpackage

// File: rtl/alu_operand_extend.sv
// rtl/alu_operand_extend.sv - combinational immediate extension of a selected operand
module alu_operand_extend
  import alu_operand_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT,
  parameter int IMM_W = ALU_IMM_W_DEFAULT
) (
  input  logic [WIDTH-1:0] i_raw,
  input  logic [1:0]       i_ext_mode,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] w_sext;
  logic [WIDTH-1:0] w_zext;
  logic [WIDTH-1:0] w_sext_sl2;

  assign w_sext     = {{(WIDTH-IMM_W){i_raw[IMM_W-1]}}, i_raw[IMM_W-1:0]};
  assign w_zext     = {{(WIDTH-IMM_W){1'b0}}, i_raw[IMM_W-1:0]};
  assign w_sext_sl2 = {w_sext[WIDTH-3:0], 2'b00};

  // Pick the extension variant requested for this operand
  always_comb begin
    o_data = i_raw;
    case (ext_mode_e'(i_ext_mode))
      EXT_PASS:     o_data = i_raw;
      EXT_SEXT:     o_data = w_sext;
      EXT_ZEXT:     o_data = w_zext;
      EXT_SEXT_SL2: o_data = w_sext_sl2;
    endcase
  end

endmodule

// File: rtl/alu_operand_sel_stage.sv
// rtl/alu_operand_sel_stage.sv - registered operand select/extend stage; ALU_OPERAND_SKID_EN adds a skid entry
module alu_operand_sel_stage
  import alu_operand_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH_DEFAULT,
  parameter int N_IN    = 6,
  parameter int IMM_W   = ALU_IMM_W_DEFAULT,
  localparam int SEL_W  = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic [1:0]            ext_mode,
  input  logic [N_IN*WIDTH-1:0] data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  sel_err
);

  logic [WIDTH-1:0] w_raw;
  logic             w_sel_err;
  logic [WIDTH-1:0] w_ext;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_err;

  // Source mux; an index with no matching source yields zero and raises the error flag
  always_comb begin
    w_raw     = '0;
    w_sel_err = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (32'(sel) == k) begin
        w_raw     = data_in[k*WIDTH +: WIDTH];
        w_sel_err = 1'b0;
      end
    end
  end

  alu_operand_extend #(
    .WIDTH (WIDTH),
    .IMM_W (IMM_W)
  ) u_extend (
    .i_raw      (w_raw),
    .i_ext_mode (ext_mode),
    .o_data     (w_ext)
  );

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign sel_err   = r_err;

`ifdef ALU_OPERAND_SKID_EN

  logic             r_ready;
  logic             r_sk_valid;
  logic [WIDTH-1:0] r_sk_data;
  logic             r_sk_err;
  logic             w_in_xfer;
  logic             w_load_main;
  logic             w_sk_next;

  assign in_ready    = r_ready;
  assign w_in_xfer   = in_valid && r_ready;
  assign w_load_main = !r_valid || out_ready;
  // Skid holds an operand only when one arrives while main is stalled
  assign w_sk_next   = !w_load_main && (r_sk_valid || w_in_xfer);

  // Main/skid pair: main refills from skid first so order is preserved
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_err      <= 1'b0;
      r_sk_valid <= 1'b0;
      r_sk_data  <= '0;
      r_sk_err   <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      if (w_load_main) begin
        if (r_sk_valid) begin
          r_valid <= 1'b1;
          r_data  <= r_sk_data;
          r_err   <= r_sk_err;
        end else begin
          r_valid <= w_in_xfer;
          if (w_in_xfer) begin
            r_data <= w_ext;
            r_err  <= w_sel_err;
          end
        end
      end else if (w_in_xfer) begin
        r_sk_data <= w_ext;
        r_sk_err  <= w_sel_err;
      end
      r_sk_valid <= w_sk_next;
      r_ready    <= !w_sk_next;
    end
  end

`else

  assign in_ready = !r_valid || out_ready;

  // Single output register: load on accept, clear valid on drain without accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else if (in_ready) begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_data <= w_ext;
        r_err  <= w_sel_err;
      end
    end
  end

`endif

endmodule

// File: doc/alu_operand_sel_stage.md
Name: alu_operand_sel_stage

Overview:
- Parametrised, registered successor to the single-cycle ALU source-B selector.
- Selects one of N_IN operand sources, applies an immediate-extension mode, and registers the result behind a valid/ready handshake.
- Sits between register-file/immediate decode and the ALU input in the pipelined datapath.
- Flags out-of-range selects instead of leaving the output undefined.

Parameters:
- WIDTH, 32, operand width in bits.
- N_IN, 6, number of selectable sources (2..16).
- SEL_W, $clog2(N_IN), select width (derived, localparam).
- IMM_W, 16, immediate field width used by extension modes; must be < WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream request valid.
- in_ready  output  1  stage can accept this cycle.
- sel  input  SEL_W  source index.
- ext_mode  input  2  extension mode, see Behaviour.
- data_in  input  N_IN*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  1  out_data holds a valid operand.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  selected, extended operand.
- sel_err  output  1  qualified by out_valid; transferred operand came from sel >= N_IN.

Behaviour:
- Reset (async assert, sync-safe release) clears state:
  - out_valid=0, out_data=0, sel_err=0.
  - in_ready=1 once reset deasserts.
  - In-flight data is discarded; no partial transfer survives reset.
- Transfer rules:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
- Selection (combinational, before the register):
  - sel < N_IN: raw = source[sel].
  - sel >= N_IN: raw = 0 and err = 1. Reachable only when N_IN is not a power of two.
- ext_mode is applied to raw:
  - 0 PASS: raw unchanged.
  - 1 SEXT: raw[IMM_W-1:0] sign-extended to WIDTH.
  - 2 ZEXT: raw[IMM_W-1:0] zero-extended.
  - 3 SEXT_SL2: SEXT result shifted left by 2, low bits zero, upper bits truncated to WIDTH.
- Latency: an operand accepted at edge N is visible on out_data/out_valid after edge N, i.e. 1 cycle.
- Base (no skid) handshake:
  - One output register.
  - in_ready = !out_valid || out_ready (combinational from out_ready).
  - Simultaneous accept and drain in the same cycle loads the new operand, so out_valid stays 1.
  - Drain without accept clears out_valid; out_data holds its last value.
  - Stall: out_valid && !out_ready keeps out_data and sel_err stable, with in_ready=0.
- Inputs are sampled only on input transfer; sel, ext_mode and data_in are don't-care otherwise.
- No data is ever dropped or duplicated. Every accepted operand is presented exactly once, in order.

Optional Feature:
- Macro: ALU_OPERAND_SKID_EN.
- Defined:
  - Adds a 2-entry skid buffer (main + skid register), giving full throughput with no combinational path from out_ready to in_ready.
  - in_ready is a registered flop: 1 when the skid entry is empty.
  - If out_ready drops while an input transfers, the operand is captured into skid.
  - Skid drains to main on the next output transfer.
  - Reset clears both entries and sets in_ready=1.
- Undefined: single-register behaviour as above.
- Ordering and latency on an unstalled path are identical either way.

Decomposition:
- Package alu_operand_pkg:
  - ext_mode_e enum: EXT_PASS=0, EXT_SEXT=1, EXT_ZEXT=2, EXT_SEXT_SL2=3.
  - Default WIDTH/IMM_W constants.
- Sub-module alu_operand_extend: purely combinational. Takes (raw, ext_mode), produces the extended value; parametrised by WIDTH and IMM_W. The top level instantiates it once, ahead of the register.

Test Plan:
- Reset mid-stall:
  - Load source 2 = 0xDEADBEEF with out_ready=0, then assert reset.
  - Expect out_valid=0 and out_data=0 immediately; in_ready=1 after release; the old operand never appears.
- Modes on 0x1234_8004 at sel=1:
  - PASS -> 0x12348004.
  - SEXT -> 0xFFFF8004.
  - ZEXT -> 0x00008004.
  - SEXT_SL2 -> 0xFFFE0010.
- Out of range, N_IN=6:
  - sel=6 and sel=7 -> out_data=0, sel_err=1.
  - Next operand with sel=0 -> sel_err=0.
- Back-to-back with out_ready=1:
  - Stream 8 operands, one per cycle (values 1..8 on sel=3).
  - Output shows 1..8 in order, one per cycle, starting 1 cycle after the first accept.
- Backpressure:
  - out_ready toggles 1,0,0,1,1,0 while in_valid is held high with incrementing data.
  - No loss or duplication.
  - Base build: in_ready tracks out_ready.
  - With ALU_OPERAND_SKID_EN: in_ready falls only after the skid entry fills, and the output sequence is identical.
- Simultaneous drain and accept while out_valid=1:
  - Old operand transfers and the new one appears the next cycle.
  - out_valid never drops to 0 in between.
